// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - prefetching instruction fetch unit with pipelined imem requests and redirect flush
// Optional 16/32-bit realignment is enabled by defining FETCH_RVC_EN.
module fetch_prefetch_unit #(
  parameter int                          RISCV_ADDR_WIDTH = 32,
  parameter int                          RISCV_WORD_WIDTH = 32,
  parameter int                          FIFO_DEPTH       = 4,
  parameter int                          MAX_OUTSTANDING  = 2,
  parameter logic [RISCV_ADDR_WIDTH-1:0] RESET_ADDR       = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] target_addr_i,
  input  logic                        target_valid_i,
  input  logic [1:0]                  retired_inst_len_i,
  output logic [RISCV_WORD_WIDTH-1:0] instr_o,
  output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
  output logic                        instr_valid_o,
  output logic                        imem_valid_o,
  input  logic                        imem_ready_i,
  output logic [RISCV_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                        imem_rvalid_i,
  input  logic [RISCV_WORD_WIDTH-1:0] imem_rdata_i,
  output logic [RISCV_WORD_WIDTH-1:0] imem_wdata_o,
  output logic [3:0]                  imem_we_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [RISCV_ADDR_WIDTH-1:0] addr_t;
  typedef logic [RISCV_WORD_WIDTH-1:0] word_t;

  localparam addr_t WORD_STEP  = addr_t'(4);
  localparam addr_t RESET_WORD = {RESET_ADDR[RISCV_ADDR_WIDTH-1:2], 2'b00};

  word_t          fifo_q [FIFO_DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [NW-1:0]  count_q, count_d;
  logic [CW-1:0]  live_q, live_d, discard_q, discard_d;
  addr_t          fetch_addr_q, fetch_addr_d, head_addr_q, head_addr_d;

  logic [31:0]    inflight, inflight_left;
  logic           rsp_tracked, rsp_drop, rsp_live, rsp_live_dec;
  logic           accept, push, pop, w0_ok;
  word_t          w0;
  addr_t          target_word;
  logic           unused_addr_lsb;

  assign imem_wdata_o    = '0;
  assign imem_we_o       = '0;
  assign unused_addr_lsb = ^target_addr_i[1:0];
  assign target_word     = {target_addr_i[RISCV_ADDR_WIDTH-1:2], 2'b00};

  // Responses with nothing tracked (left over from before a reset) must not underflow the counters.
  assign inflight      = 32'(live_q) + 32'(discard_q);
  assign rsp_tracked   = imem_rvalid_i && (inflight != 32'd0);
  assign inflight_left = inflight - 32'(rsp_tracked);

  always_comb begin
    imem_valid_o = 1'b0;
    imem_addr_o  = fetch_addr_q;
    if (!rst) begin
      if (target_valid_i) begin
        imem_addr_o  = target_word;
        imem_valid_o = inflight_left < 32'(MAX_OUTSTANDING);
      end else begin
        imem_valid_o = req_i && (32'(count_q) + 32'(live_q) < 32'(FIFO_DEPTH))
                             && (inflight < 32'(MAX_OUTSTANDING));
      end
    end
  end

  assign accept       = imem_valid_o && imem_ready_i;
  assign rsp_drop     = imem_rvalid_i && (discard_q != '0);
  assign rsp_live     = imem_rvalid_i && (discard_q == '0) && !target_valid_i;
  assign rsp_live_dec = rsp_live && (live_q != '0);
  assign push         = rsp_live && ((count_q < NW'(FIFO_DEPTH)) || pop);

  assign w0    = fifo_q[rd_ptr_q];
  assign w0_ok = count_q != '0;

`ifdef FETCH_RVC_EN
  logic  hw_q, hw_d, w1_ok;
  word_t w1, head_raw;

  assign w1    = fifo_q[rd_ptr_q + PW'(1)];
  assign w1_ok = count_q > NW'(1);

  // With hw set the head instruction starts in the upper half of W0 and may spill into W1.
  always_comb begin
    if (!hw_q) begin
      head_raw      = w0;
      instr_valid_o = w0_ok;
    end else begin
      head_raw      = {(w1_ok ? w1[15:0] : 16'h0000), w0[31:16]};
      instr_valid_o = w0_ok && ((w0[17:16] != 2'b11) || w1_ok);
    end
  end

  assign instr_o      = instr_valid_o ? head_raw : '0;
  assign instr_addr_o = head_addr_q + addr_t'({hw_q, 1'b0});
  assign pop          = instr_valid_o && (((retired_inst_len_i == 2'd1) && hw_q) ||
                                          (retired_inst_len_i == 2'd2));

  always_comb begin
    hw_d = hw_q;
    if (target_valid_i)
      hw_d = target_addr_i[1];
    else if (instr_valid_o && (retired_inst_len_i == 2'd1))
      hw_d = ~hw_q;
  end

  always_ff @(posedge clk) begin
    if (rst) hw_q <= 1'b0;
    else     hw_q <= hw_d;
  end
`else
  assign instr_valid_o = w0_ok;
  assign instr_o       = w0_ok ? w0 : '0;
  assign instr_addr_o  = head_addr_q;
  assign pop           = instr_valid_o && (retired_inst_len_i != 2'd0);
`endif

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    head_addr_d  = head_addr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    live_d       = live_q;
    discard_d    = discard_q;
    if (target_valid_i) begin
      // Everything still in flight belongs to the old stream; only the target request is live.
      head_addr_d  = target_word;
      rd_ptr_d     = wr_ptr_q;
      count_d      = '0;
      discard_d    = CW'(inflight_left);
      live_d       = CW'(accept);
      fetch_addr_d = accept ? target_word + WORD_STEP : target_word;
    end else begin
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PW'(1);
        head_addr_d = head_addr_q + WORD_STEP;
      end
      if (push)
        wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + NW'(push) - NW'(pop);
      if (rsp_drop)
        discard_d = discard_q - CW'(1);
      live_d = live_q + CW'(accept) - CW'(rsp_live_dec);
      if (accept)
        fetch_addr_d = fetch_addr_q + WORD_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr_q <= RESET_WORD;
      head_addr_q  <= RESET_WORD;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      live_q       <= '0;
      discard_q    <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      head_addr_q  <= head_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      live_q       <= live_d;
      discard_q    <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr_q] <= imem_rdata_i;
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - scoreboard bench for fetch_prefetch_unit with an in-order latency memory model
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst, req_i, target_valid_i, instr_valid_o;
  logic        imem_valid_o, imem_ready_i, imem_rvalid_i;
  logic [31:0] target_addr_i, instr_o, instr_addr_o, imem_addr_o, imem_rdata_i, imem_wdata_o;
  logic [1:0]  retired_inst_len_i;
  logic [3:0]  imem_we_o;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .RISCV_ADDR_WIDTH(32), .RISCV_WORD_WIDTH(32),
    .FIFO_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_ADDR(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i),
    .target_addr_i(target_addr_i), .target_valid_i(target_valid_i),
    .retired_inst_len_i(retired_inst_len_i),
    .instr_o(instr_o), .instr_addr_o(instr_addr_o), .instr_valid_o(instr_valid_o),
    .imem_valid_o(imem_valid_o), .imem_ready_i(imem_ready_i), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .imem_wdata_o(imem_wdata_o), .imem_we_o(imem_we_o)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [31:0] mask; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] ovr [logic [31:0]];
  int          cyc = 0, lat = 1, resp_508_cyc = -100;
  int          n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return {a[15:0], 16'h0013};
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    exp_q.push_back('{addr: a, data: d, mask: m});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_imem_valid"}, 32'(imem_valid_o), 32'd0);
    check({tag, "_instr_valid"}, 32'(instr_valid_o), 32'd0);
    check({tag, "_instr"}, instr_o, 32'd0);
    check({tag, "_instr_addr"}, instr_addr_o, 32'h100);
  endtask

  task automatic wait_drained(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Memory: in-order responses, lat cycles after acceptance; reset together with the DUT.
  initial begin
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = memval(pend[0].addr);
        if (pend[0].addr == 32'h508) resp_508_cyc = cyc;
        void'(pend.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
      end
      @(negedge clk);
      if (rst) pend.delete();
      else if (imem_valid_o && imem_ready_i) begin
        pend.push_back('{addr: imem_addr_o, due: cyc + lat});
        req_log.push_back(imem_addr_o);
      end
    end
  end

  // Monitor: every instruction the decoder actually consumes is checked against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !target_valid_i && instr_valid_o &&
          (retired_inst_len_i == 2'd1 || retired_inst_len_i == 2'd2)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_consume", instr_addr_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("consume_addr", instr_addr_o, e.addr);
          check("consume_data", instr_o & e.mask, e.data & e.mask);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    int vcyc;
    ovr[32'h300] = 32'h0001_1234;
    ovr[32'h304] = 32'h0000_0013;
    ovr[32'h504] = 32'h4567_1111;
    ovr[32'h508] = 32'h2222_89AB;

    rst = 1'b1; req_i = 1'b0; target_valid_i = 1'b0; target_addr_i = '0;
    retired_inst_len_i = 2'd0; imem_ready_i = 1'b1; lat = 1;
    repeat (2) step();
    sample();
    check_reset("reset1");

    // Stream from RESET_ADDR with 1-cycle memory
    step(); rst = 1'b0; req_i = 1'b1;
    n = -1;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (instr_valid_o) begin n = i; break; end
    end
    check("first_valid_delay", 32'(n), 32'd2);
    check("first_instr_addr", instr_addr_o, 32'h100);
    check("first_instr_data", instr_o, 32'h0100_0013);

    // Backpressure: idle consumer stops issue after exactly FIFO_DEPTH words
    repeat (10) step();
    sample();
    check("bp_req_count", 32'(req_log.size()), 32'd4);
    check("bp_imem_valid", 32'(imem_valid_o), 32'd0);
    step(); push_exp(32'h100, 32'h0100_0013, 32'hFFFF_FFFF); retired_inst_len_i = 2'd2;
    step(); retired_inst_len_i = 2'd0;
    repeat (6) step();
    sample();
    check("bp_req_count_after_pop", 32'(req_log.size()), 32'd5);
    check("bp_extra_req_addr", req_log[req_log.size()-1], 32'h110);
    check("bp_imem_valid_after", 32'(imem_valid_o), 32'd0);

    step();
    for (int k = 0; k < 8; k++) push_exp(32'h104 + 4*k, {16'h0104 + 16'(4*k), 16'h0013}, 32'hFFFF_FFFF);
    retired_inst_len_i = 2'd2;
    wait_drained("stream");
    retired_inst_len_i = 2'd0;
    for (int i = 0; i < req_log.size(); i++) check("stream_req_addr", req_log[i], 32'h100 + 32'(4*i));

    // Reset mid-operation, then flush with two 3-cycle requests in flight
    rst = 1'b1;
    step(); step();
    sample();
    check_reset("reset2");
    req_log.delete();
    step(); rst = 1'b0; lat = 3;
    for (int i = 0; i < 50 && req_log.size() < 4; i++) step();
    check("flush_req_count", 32'(req_log.size()), 32'd4);
    check("flush_req2", req_log[2], 32'h108);
    check("flush_req3", req_log[3], 32'h10C);
    target_valid_i = 1'b1; target_addr_i = 32'h200; retired_inst_len_i = 2'd2;
    sample();
    check("flush_target_blocked", 32'(imem_valid_o), 32'd0);
    step(); target_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) push_exp(32'h200 + 4*k, {16'h0200 + 16'(4*k), 16'h0013}, 32'hFFFF_FFFF);
    for (int i = 0; i < 50 && req_log.size() < 5; i++) step();
    check("flush_target_req", req_log[4], 32'h200);
    wait_drained("flush");
    retired_inst_len_i = 2'd0;

    // Redirect with req_i low, 1-cycle memory: instruction at T+2
    req_i = 1'b0;
    repeat (12) step();
    lat = 1;
    target_valid_i = 1'b1; target_addr_i = 32'h400;
    sample();
    check("redir_imem_valid", 32'(imem_valid_o), 32'd1);
    check("redir_imem_addr", imem_addr_o, 32'h400);
    step(); target_valid_i = 1'b0;
    sample();
    check("redir_t1_valid", 32'(instr_valid_o), 32'd0);
    check("redir_t1_imem_valid", 32'(imem_valid_o), 32'd0);
    step();
    sample();
    check("redir_t2_valid", 32'(instr_valid_o), 32'd1);
    check("redir_t2_addr", instr_addr_o, 32'h400);
    check("redir_t2_data", instr_o, 32'h0400_0013);

`ifdef FETCH_RVC_EN
    // Compressed instruction in the upper half of a word
    step(); req_i = 1'b1; target_valid_i = 1'b1; target_addr_i = 32'h302;
    step(); target_valid_i = 1'b0;
    step();
    sample();
    check("rvc_valid", 32'(instr_valid_o), 32'd1);
    check("rvc_addr", instr_addr_o, 32'h302);
    check("rvc_data", instr_o & 32'h0000_FFFF, 32'h0000_0001);
    step(); push_exp(32'h302, 32'h0000_0001, 32'h0000_FFFF); retired_inst_len_i = 2'd1;
    step(); retired_inst_len_i = 2'd0;
    sample();
    check("rvc_next_addr", instr_addr_o, 32'h304);
    check("rvc_next_data", instr_o, 32'h0000_0013);

    // 32-bit instruction straddling two words
    step(); lat = 3; target_valid_i = 1'b1; target_addr_i = 32'h506;
    step(); target_valid_i = 1'b0;
    vcyc = -1;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (instr_valid_o) begin vcyc = cyc; break; end
    end
    check("straddle_valid_cycle", 32'(vcyc), 32'(resp_508_cyc + 1));
    check("straddle_addr", instr_addr_o, 32'h506);
    check("straddle_data", instr_o, 32'h89AB_4567);
    step(); push_exp(32'h506, 32'h89AB_4567, 32'hFFFF_FFFF); retired_inst_len_i = 2'd2;
    step(); retired_inst_len_i = 2'd0;
`endif

    repeat (5) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
